knn_scheduler: RTL and testbench

KNN_SCHEDULER -- requirements
Module: knn_scheduler

---
 rtl/knn_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_knn_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/knn_scheduler.sv
// knn_scheduler: sequences a kNN classification run.
// For each test vector it loads the test word, streams TRAIN_SIZE training
// words into the kNN pipeline, then waits for the pipeline's result and
// writes {timeout, correct, label} to the result memory.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               run request, sampled in IDLE only
//   busy, done          run in progress / one-cycle completion pulse
//   train_addr/rdata    training memory read port (1-cycle read latency)
//   test_addr/rdata     test memory read port (1-cycle read latency)
//   knn_rst             synchronous clear for the kNN pipeline
//   knn_test_data, knn_train_data, knn_label, knn_index   stream to kNN
//   knn_res, knn_res_vld                                  kNN result
//   res_wr, res_addr, res_wdata   result write port
//   n_correct, n_all, err         run statistics and sticky protocol error
//
// Optional feature: define KNN_SCHED_TIMEOUT_EN to abandon a test vector
// after TIMEOUT cycles in WAIT without a result.
module knn_scheduler #(
  parameter int unsigned TRAIN_SIZE = 75,
  parameter int unsigned TEST_SIZE  = 75,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  train_addr,
  output logic [7:0]  test_addr,
  input  logic [33:0] train_rdata,
  input  logic [33:0] test_rdata,
  output logic        knn_rst,
  output logic [31:0] knn_test_data,
  output logic [31:0] knn_train_data,
  output logic [1:0]  knn_label,
  output logic [7:0]  knn_index,
  input  logic [1:0]  knn_res,
  input  logic        knn_res_vld,
  output logic        res_wr,
  output logic [7:0]  res_addr,
  output logic [3:0]  res_wdata,
  output logic [7:0]  n_correct,
  output logic [7:0]  n_all,
  output logic        err
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 2;

  // Elaboration-time parameter range guard.
  if (TRAIN_SIZE < 1 || TRAIN_SIZE > 255 || TEST_SIZE < 1 || TEST_SIZE > 255 ||
      TIMEOUT < 1) begin : g_param_check
    $error("knn_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] test_idx_q, test_idx_d;
  logic [AW-1:0] train_addr_d;
  logic [AW-1:0] knn_index_d;
  logic [AW-1:0] n_correct_d, n_all_d;
  logic          err_d;
  logic          busy_d, done_d;
  logic          knn_rst_q, knn_rst_d;
  logic          accept_c;
  logic          timeout_c;
  logic          match_c;
  logic          stream_c;

`ifdef KNN_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      test_idx_q <= '0;
      train_addr <= '0;
      knn_index  <= '0;
      n_correct  <= '0;
      n_all      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      knn_rst_q  <= 1'b1;
`ifdef KNN_SCHED_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      test_idx_q <= test_idx_d;
      train_addr <= train_addr_d;
      knn_index  <= knn_index_d;
      n_correct  <= n_correct_d;
      n_all      <= n_all_d;
      err        <= err_d;
      busy       <= busy_d;
      done       <= done_d;
      knn_rst_q  <= knn_rst_d;
`ifdef KNN_SCHED_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d     = state_q;
    test_idx_d  = test_idx_q;
    n_correct_d = n_correct;
    n_all_d     = n_all;
    err_d       = err;
    accept_c    = 1'b0;
    timeout_c   = 1'b0;
    match_c     = (knn_res == test_rdata[33:32]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          test_idx_d  = '0;
          n_correct_d = '0;
          n_all_d     = '0;
          err_d       = 1'b0;
        end
      end
      S_LOAD: begin
        if (knn_res_vld) err_d = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (knn_res_vld) err_d = 1'b1;
        // train_addr runs one ahead of the delivered index.
        if (train_addr == AW'(TRAIN_SIZE)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (knn_res_vld) begin
          accept_c = 1'b1;
        end
`ifdef KNN_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
        end
`endif
        if (accept_c || timeout_c) begin
          n_all_d = n_all + AW'(1);
          if (accept_c && match_c) n_correct_d = n_correct + AW'(1);
          if (timeout_c) err_d = 1'b1;
          if (test_idx_q == AW'(TEST_SIZE - 1)) begin
            state_d = S_DONE;
          end else begin
            test_idx_d = test_idx_q + AW'(1);
            state_d    = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    train_addr_d = (state_d == S_STREAM) ? train_addr + AW'(1) : '0;
    knn_index_d  = (state_d == S_STREAM) ? train_addr : '0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    knn_rst_d    = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
  end

`ifdef KNN_SCHED_TIMEOUT_EN
  // WAIT-cycle counter, zero on the first WAIT cycle.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) wait_cnt_d = wait_cnt_q + CW'(1);
  end
`endif

  // Memory read data passes straight through while streaming.
  assign stream_c       = (state_q == S_STREAM);
  assign knn_train_data = stream_c ? train_rdata[DW-1:0] : '0;
  assign knn_label      = stream_c ? train_rdata[DW+LW-1:DW] : '0;
  assign knn_test_data  = stream_c ? test_rdata[DW-1:0] : '0;
  assign test_addr      = test_idx_q;

  // Result write happens in the accepting cycle itself.
  assign knn_rst   = knn_rst_q | accept_c;
  assign res_wr    = accept_c | timeout_c;
  assign res_addr  = res_wr ? test_idx_q : '0;
  assign res_wdata = accept_c  ? {1'b0, match_c, knn_res} :
                     timeout_c ? 4'b1000 : 4'b0000;

endmodule

// File: tb/tb_knn_scheduler.sv
// Self-checking bench for knn_scheduler: random memory contents and result
// labels, expected stream and statistics computed from the run rules.
module tb_knn_scheduler;

  localparam int unsigned TRS = 12;
  localparam int unsigned TES = 4;
  localparam int unsigned TO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic [7:0]  train_addr, test_addr;
  logic [33:0] train_rdata, test_rdata;
  logic        knn_rst;
  logic [31:0] knn_test_data, knn_train_data;
  logic [1:0]  knn_label;
  logic [7:0]  knn_index;
  logic [1:0]  knn_res;
  logic        knn_res_vld;
  logic        res_wr;
  logic [7:0]  res_addr;
  logic [3:0]  res_wdata;
  logic [7:0]  n_correct, n_all;
  logic        err;

  logic [33:0] train_mem [0:255];
  logic [33:0] test_mem  [0:255];

  int n_cmp = 0;
  int n_mis = 0;

  knn_scheduler #(.TRAIN_SIZE(TRS), .TEST_SIZE(TES), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .train_addr(train_addr), .test_addr(test_addr),
    .train_rdata(train_rdata), .test_rdata(test_rdata),
    .knn_rst(knn_rst), .knn_test_data(knn_test_data),
    .knn_train_data(knn_train_data), .knn_label(knn_label),
    .knn_index(knn_index), .knn_res(knn_res), .knn_res_vld(knn_res_vld),
    .res_wr(res_wr), .res_addr(res_addr), .res_wdata(res_wdata),
    .n_correct(n_correct), .n_all(n_all), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    train_rdata <= train_mem[train_addr];
    test_rdata  <= test_mem[test_addr];
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full run; called at a negedge with the DUT in IDLE, returns the same way.
  task automatic do_run(input bit hold_start, input bit inj_err, input int rst_at,
                        input logic [7:0] mism, input bit to_first);
    int         exp_nc;
    int         exp_na;
    bit         exp_err;
    logic [1:0] tl;
    logic [1:0] r;
    bit         m;
    int         gap;
    exp_nc = 0; exp_na = 0; exp_err = 1'b0;
    start = 1'b1;
    #1 check("idle_busy", 96'(busy), 96'(1'b0));
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int t = 0; t < int'(TES); t++) begin
      #1 check("load", 96'({busy, knn_rst, done, test_addr, knn_index, train_addr}),
               96'({1'b1, 1'b1, 1'b0, 8'(t), 8'd0, 8'd0}));
      @(negedge clk);
      for (int k = 0; k < int'(TRS); k++) begin
        if (inj_err && k == 1) begin
          knn_res_vld = 1'b1;
          knn_res     = 2'($urandom);
          exp_err     = 1'b1;
        end
        #1 check("stream", 96'({knn_index, knn_label, knn_train_data, knn_test_data, knn_rst, busy}),
                 96'({8'(k), train_mem[k][33:32], train_mem[k][31:0], test_mem[t][31:0], 1'b0, 1'b1}));
        check("stream_addr", 96'(train_addr), 96'(8'(k + 1)));
        if (inj_err && k == 1) check("stray_wr", 96'(res_wr), 96'(1'b0));
        if (rst_at == t && k == 10) begin
          #1 rst = 1'b1;
          knn_res_vld = 1'b0;
          #1 check("async_rst", 96'({busy, done, knn_rst, knn_index, knn_label, knn_train_data, res_wr, train_addr}),
                   96'({1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 32'd0, 1'b0, 8'd0}));
          check("async_rst2", 96'({test_addr, n_all, n_correct, err, knn_test_data}),
                96'({8'd0, 8'd0, 8'd0, 1'b0, 32'd0}));
          start = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("post_rst_idle", 96'({busy, done, res_wr}), 96'({1'b0, 1'b0, 1'b0}));
          end
          @(negedge clk);
          return;
        end
        @(negedge clk);
        knn_res_vld = 1'b0;
      end
`ifdef KNN_SCHED_TIMEOUT_EN
      if (to_first && t == 0) begin
        for (int w = 0; w < int'(TO) - 1; w++) begin
          #1 check("to_wait", 96'(res_wr), 96'(1'b0));
          @(negedge clk);
        end
        #1 check("to_wr", 96'({res_wr, res_addr, res_wdata}), 96'({1'b1, 8'(t), 4'b1000}));
        exp_na++;
        exp_err = 1'b1;
        @(negedge clk);
        continue;
      end
`else
      if (to_first) check("to_unsupported", 96'(1'b0), 96'(1'b0 ^ to_first ^ to_first));
`endif
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        #1 check("wait_idle", 96'({res_wr, knn_rst, knn_index, knn_train_data}), 96'({1'b0, 1'b0, 8'd0, 32'd0}));
        @(negedge clk);
      end
      tl = test_mem[t][33:32];
      r  = mism[t] ? (tl ^ 2'($urandom_range(1, 3))) : tl;
      m  = (r == tl);
      knn_res     = r;
      knn_res_vld = 1'b1;
      #1 check("result", 96'({res_wr, res_addr, res_wdata, knn_rst}),
               96'({1'b1, 8'(t), {1'b0, m, r}, 1'b1}));
      exp_na++;
      if (m) exp_nc++;
      @(negedge clk);
      knn_res_vld = 1'b0;
    end
    // DONE: a stray result here must be ignored silently.
    knn_res_vld = 1'b1;
    knn_res     = 2'($urandom);
    #1 check("done", 96'({done, busy, res_wr, knn_rst}), 96'({1'b1, 1'b1, 1'b0, 1'b1}));
    @(negedge clk);
    knn_res_vld = 1'b0;
    #1 check("idle_after", 96'({done, busy}), 96'({1'b0, 1'b0}));
    check("stats", 96'({n_correct, n_all, err}), 96'({8'(exp_nc), 8'(exp_na), exp_err}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      train_mem[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
      test_mem[i]  = {2'($urandom_range(0, 3)), 32'($urandom)};
    end
    rst = 1'b1;
    start = 1'b0;
    knn_res_vld = 1'b0;
    knn_res = 2'd0;
    repeat (3) @(negedge clk);
    #1 check("rst_state",
             96'({busy, done, knn_rst, train_addr, test_addr, knn_index, res_wr, n_correct, n_all, err, knn_train_data}),
             96'({1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'd0}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Result valid in IDLE is ignored.
    knn_res_vld = 1'b1;
    #1 check("idle_vld", 96'({res_wr, busy}), 96'({1'b0, 1'b0}));
    @(negedge clk);
    knn_res_vld = 1'b0;
    #1 check("idle_vld_err", 96'({err, n_all}), 96'({1'b0, 8'd0}));
    @(negedge clk);

    do_run(1'b0, 1'b0, -1, 8'b0000_0010, 1'b0);
    do_run(1'b0, 1'b1, -1, 8'($urandom), 1'b0);
    do_run(1'b1, 1'b0, -1, 8'($urandom), 1'b0);
    do_run(1'b0, 1'b0, -1, 8'($urandom), 1'b0);
    do_run(1'b0, 1'b0, 1, 8'($urandom), 1'b0);
    do_run(1'b0, 1'b0, -1, 8'($urandom), 1'b0);
`ifdef KNN_SCHED_TIMEOUT_EN
    do_run(1'b0, 1'b0, -1, 8'($urandom), 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
